// File: rtl/pc_target_table.sv
// pc_target_table: writable, direct-indexed branch-target table with valid
// bits and an integrated program counter.
//
// Each cycle fetch presents branch_tag. The table answers hit/target
// combinationally, and on the edge the PC either increments or jumps to the
// stored target. Entries are programmed through wr_*. clear_req starts a
// DEPTH-edge sweep that invalidates one entry per edge. Bad writes and branch
// misses set a sticky err flag that only Reset clears.
//
// Ports
//   Clk, Reset            clock, async active-high reset
//   stall                 hold PC this cycle
//   branch_req/branch_tag table branch request and lookup tag
//   wr_en/wr_tag/wr_target  program one entry
//   clear_req             start clearing all valid bits
//   pc                    current program counter
//   target, hit           combinational lookup result (target=0 on miss)
//   taken                 PC was loaded from the table on the previous edge
//   busy                  clear sweep in progress
//   valid_count           number of valid entries
//   err                   sticky error flag
module pc_target_table #(
  parameter int TAG_W = 8,
  parameter int PC_W  = 12,
  parameter int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             stall,
  input  logic             branch_req,
  input  logic [TAG_W-1:0] branch_tag,
  input  logic             wr_en,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [PC_W-1:0]  wr_target,
  input  logic             clear_req,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  target,
  output logic             hit,
  output logic             taken,
  output logic             busy,
  output logic [CNT_W-1:0] valid_count,
  output logic             err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**TAG_W still compares correctly.
  localparam logic [TAG_W:0]   DEPTH_T = (TAG_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DEPTH-1:0] valid_q;
  logic [PC_W-1:0]  mem [DEPTH];

  logic             br_in, wr_in, clr_en, do_wr, wr_err, br_go;
  logic [IDX_W-1:0] br_idx, wr_idx;

  // Lookup on current contents; a same-edge write is not bypassed.
  assign br_in  = {1'b0, branch_tag} < DEPTH_T;
  assign wr_in  = {1'b0, wr_tag} < DEPTH_T;
  assign br_idx = branch_tag[IDX_W-1:0];
  assign wr_idx = wr_tag[IDX_W-1:0];
  assign hit    = br_in & valid_q[br_idx];
  assign target = hit ? mem[br_idx] : '0;

  assign busy   = (state_q == CLEAR);
  assign do_wr  = wr_en & ~busy & wr_in;
  assign wr_err = wr_en & (busy | ~wr_in);
  assign br_go  = ~busy & ~stall;

  // Clear sweep: one entry per edge, index 0..DEPTH-1, then back to IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clr_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        clr_en = 1'b1;
        idx_d  = idx_q + IDX_W'(1);
        if (idx_q == LAST) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      valid_q     <= '0;
      valid_count <= '0;
      pc          <= '0;
      taken       <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;

      // Writes only happen in IDLE and clears only in CLEAR, so the two
      // valid_count adjustments never collide.
      if (do_wr) begin
        valid_q[wr_idx] <= 1'b1;
        if (!valid_q[wr_idx]) valid_count <= valid_count + CNT_W'(1);
      end
      if (clr_en) begin
        valid_q[idx_q] <= 1'b0;
        if (valid_q[idx_q]) valid_count <= valid_count - CNT_W'(1);
      end

      taken <= 1'b0;
      if (br_go) begin
        if (branch_req && hit) begin
          pc    <= target;
          taken <= 1'b1;
        end else begin
          pc <= pc + PC_W'(1);
        end
      end

      if (wr_err || (br_go && branch_req && !hit)) err <= 1'b1;
    end
  end

  // Target storage is deliberately left out of reset; valid bits gate it.
  always_ff @(posedge Clk) begin
    if (do_wr) mem[wr_idx] <= wr_target;
  end

endmodule

// File: tb/tb_pc_target_table.sv
// Randomized + directed bench for pc_target_table against a behavioural
// model of the table (arrays of entries, a remaining-clear counter).
module tb_pc_target_table;
  localparam int TAG_W = 8;
  localparam int PC_W  = 12;
  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             Clk = 1'b0, Reset = 1'b1;
  logic             stall = 0, branch_req = 0, wr_en = 0, clear_req = 0;
  logic [TAG_W-1:0] branch_tag = '0, wr_tag = '0;
  logic [PC_W-1:0]  wr_target = '0;
  logic [PC_W-1:0]  pc, target;
  logic             hit, taken, busy, err;
  logic [CNT_W-1:0] valid_count;

  pc_target_table #(.TAG_W(TAG_W), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .stall(stall), .branch_req(branch_req),
    .branch_tag(branch_tag), .wr_en(wr_en), .wr_tag(wr_tag),
    .wr_target(wr_target), .clear_req(clear_req), .pc(pc), .target(target),
    .hit(hit), .taken(taken), .busy(busy), .valid_count(valid_count), .err(err)
  );

  always #5 Clk = ~Clk;

  int checks = 0, errors = 0;

  // Reference model
  bit m_v[DEPTH];
  int m_t[DEPTH];
  int m_pc, m_clr_left;
  bit m_taken, m_err;

  function automatic bit m_hit(int tag);
    return (tag < DEPTH) && m_v[tag];
  endfunction

  function automatic int m_target(int tag);
    return m_hit(tag) ? m_t[tag] : 0;
  endfunction

  function automatic int m_cnt();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_v[i]);
    return n;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_pc = 0; m_taken = 0; m_err = 0; m_clr_left = 0;
    for (int i = 0; i < DEPTH; i++) m_v[i] = 0;
  endtask

  task automatic model_edge();
    int bt = int'(branch_tag);
    int wt = int'(wr_tag);
    bit bsy = m_clr_left > 0;
    bit h = m_hit(bt);
    int tg = m_target(bt);
    if (bsy || stall) m_taken = 0;
    else if (branch_req && h) begin m_pc = tg; m_taken = 1; end
    else begin
      m_pc = (m_pc + 1) % (1 << PC_W);
      m_taken = 0;
      if (branch_req) m_err = 1;
    end
    if (wr_en) begin
      if (!bsy && wt < DEPTH) begin m_v[wt] = 1; m_t[wt] = int'(wr_target); end
      else m_err = 1;
    end
    if (bsy) begin m_v[DEPTH - m_clr_left] = 0; m_clr_left--; end
    else if (clear_req) m_clr_left = DEPTH;
  endtask

  task automatic cycle();
    #1;
    chk("hit", 32'(hit), 32'(m_hit(int'(branch_tag))));
    chk("target", 32'(target), 32'(m_target(int'(branch_tag))));
    @(posedge Clk);
    model_edge();
    #1;
    chk("pc", 32'(pc), 32'(m_pc));
    chk("taken", 32'(taken), 32'(m_taken));
    chk("busy", 32'(busy), 32'(m_clr_left > 0));
    chk("vcount", 32'(valid_count), 32'(m_cnt()));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic idle();
    stall = 0; branch_req = 0; wr_en = 0; clear_req = 0;
  endtask

  task automatic apply_reset();
    Reset = 1;
    #2;
    m_reset();
    chk("rst_pc", 32'(pc), 0);
    chk("rst_taken", 32'(taken), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_vcount", 32'(valid_count), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_hit", 32'(hit), 0);
    chk("rst_target", 32'(target), 0);
    Reset = 0;
  endtask

  task automatic wr(int tag, int tgt);
    idle(); wr_en = 1; wr_tag = TAG_W'(tag); wr_target = PC_W'(tgt);
    cycle();
    idle();
  endtask

  task automatic br(int tag);
    idle(); branch_req = 1; branch_tag = TAG_W'(tag);
    cycle();
    idle();
  endtask

  initial begin
    int n, pc_hold;
    apply_reset();

    // Idle edges from reset
    for (int i = 0; i < 5; i++) cycle();
    chk("pc5", 32'(pc), 5);

    // Program and jump
    wr(3, 'h2A0);
    idle(); branch_req = 1; branch_tag = 3;
    #1;
    chk("hit3", 32'(hit), 1);
    chk("tgt3", 32'(target), 'h2A0);
    cycle();
    chk("jump", 32'(pc), 'h2A0);
    chk("taken1", 32'(taken), 1);
    idle(); cycle();
    chk("taken0", 32'(taken), 0);
    wr(3, 'h2A4);
    chk("rewrite_cnt", 32'(valid_count), 1);

    // Miss sets err
    wr(1, 'h010);
    br(1);
    br(7);
    chk("miss_pc", 32'(pc), 'h011);
    chk("miss_err", 32'(err), 1);
    apply_reset();
    wr(DEPTH, 'h123);
    chk("oor_err", 32'(err), 1);
    chk("oor_cnt", 32'(valid_count), 0);

    // Clear sweep with traffic
    wr(0, 'h11); wr(4, 'h44); wr(15, 'h77);
    chk("cnt3", 32'(valid_count), 3);
    idle(); clear_req = 1; cycle();
    pc_hold = int'(pc);
    n = 0;
    branch_req = 1; branch_tag = 4; wr_en = 1; wr_tag = 2; clear_req = 1;
    while (busy === 1'b1 && n < 40) begin cycle(); n++; end
    chk("clr_len", n, DEPTH);
    chk("clr_pc", 32'(pc), 32'(pc_hold));
    chk("clr_err", 32'(err), 1);
    idle();
    for (int t = 0; t < DEPTH + 2; t++) begin branch_tag = TAG_W'(t); cycle(); end

    // Same-edge write and branch: branch sees old contents
    wr(5, 'h080);
    idle(); branch_req = 1; branch_tag = 5; wr_en = 1; wr_tag = 5; wr_target = 'h100;
    cycle();
    chk("nobypass_pc", 32'(pc), 'h080);
    idle(); branch_tag = 5; #1;
    chk("newtgt", 32'(target), 'h100);
    cycle();

    // Same-edge write and clear_req
    idle(); wr_en = 1; wr_tag = 9; wr_target = 'h999; clear_req = 1; cycle();
    chk("wr_then_clr", 32'(valid_count), 32'(m_cnt()));
    idle();
    for (int i = 0; i < DEPTH; i++) cycle();

    // PC wrap
    wr(9, 'hFFF);
    br(9);
    chk("pcfff", 32'(pc), 'hFFF);
    cycle();
    chk("wrap", 32'(pc), 0);

    // Reset in the middle of a clear (idx=6)
    idle(); clear_req = 1; cycle();
    idle();
    for (int i = 0; i < 6; i++) cycle();
    chk("midclr_busy", 32'(busy), 1);
    apply_reset();
    cycle();
    chk("post_rst_busy", 32'(busy), 0);

    // Random traffic
    for (int b = 0; b < 4; b++) begin
      apply_reset();
      for (int i = 0; i < 400; i++) begin
        stall      = ($urandom % 4) == 0;
        branch_req = ($urandom % 2) == 0;
        branch_tag = TAG_W'($urandom_range(0, DEPTH + 3));
        wr_en      = ($urandom % 3) == 0;
        wr_tag     = TAG_W'($urandom_range(0, DEPTH + 1));
        wr_target  = ($urandom % 8 == 0) ? PC_W'('hFFF) : PC_W'($urandom);
        clear_req  = ($urandom % 50) == 0;
        cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
